// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its IF/ID register.
// Holds reset/base address defaults, the NOP encoding, the next-PC select
// encoding, and small helpers for address arithmetic.
package cpu_pkg;

   localparam int          XLEN          = 32;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
   localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

   // Source selected for the next PC value
   typedef enum logic [1:0] {
      PC_SEL_RESET    = 2'b00,
      PC_SEL_REDIRECT = 2'b01,
      PC_SEL_HOLD     = 2'b10,
      PC_SEL_ADVANCE  = 2'b11
   } pc_sel_e;

   // Byte offset from the memory base, expressed in words (no range check)
   function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      logic [31:0] diff;
      diff = addr - base;
      return diff >> 2;
   endfunction

   // True when a byte address is not word aligned
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: valid/pc/instr with priority
// reset > flush (bubble) > hold > load.
module ifid_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        hold,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   logic        valid_r;
   logic [31:0] pc_r;
   logic [31:0] instr_r;

   // Pipeline register update: a flush inserts a NOP bubble even when held
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         pc_r    <= 32'h0000_0000;
         instr_r <= NOP_INSTR;
      end else if (flush) begin
         valid_r <= 1'b0;
         pc_r    <= 32'h0000_0000;
         instr_r <= NOP_INSTR;
      end else if (hold) begin
         valid_r <= valid_r;
         pc_r    <= pc_r;
         instr_r <= instr_r;
      end else begin
         valid_r <= 1'b1;
         pc_r    <= load_pc;
         instr_r <= load_instr;
      end
   end

   assign valid = valid_r;
   assign pc    = pc_r;
   assign instr = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: architectural PC register, next-PC mux,
// sticky misaligned-redirect flag and the IF/ID register.
// Optional feature macro: FETCH_FLUSH_COUNT_EN enables a saturating
// redirect-cycle counter on flush_cnt; otherwise flush_cnt reads 0.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
   parameter int          IMEM_AW   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        newpc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        pc,
   output logic               pcen,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_instr,
   output logic               id_valid,
   output logic               misalign,
   output logic [15:0]        flush_cnt
);

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] word_off_s;
   logic        misalign_r;
   pc_sel_e     pc_sel_s;

   // Choose the next-PC source: reset > redirect > stall > advance
   always_comb begin
      pc_sel_s = PC_SEL_ADVANCE;
      if (rst) begin
         pc_sel_s = PC_SEL_RESET;
      end else if (redirect) begin
         pc_sel_s = PC_SEL_REDIRECT;
      end else if (stall) begin
         pc_sel_s = PC_SEL_HOLD;
      end else begin
         pc_sel_s = PC_SEL_ADVANCE;
      end
   end

   // Next-PC mux; redirect targets are forced to word alignment and
   // the advance path wraps silently at the top of the address space
   always_comb begin
      pc_next_s = pc_r;
      case (pc_sel_s)
         PC_SEL_RESET:    pc_next_s = RESET_PC;
         PC_SEL_REDIRECT: pc_next_s = {newpc[31:2], 2'b00};
         PC_SEL_HOLD:     pc_next_s = pc_r;
         PC_SEL_ADVANCE:  pc_next_s = pc_r + 32'd4;
         default:         pc_next_s = RESET_PC;
      endcase
   end

   // Architectural PC register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   // Sticky flag recording any misaligned redirect target until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_r <= 1'b0;
      end else if (redirect) begin
         misalign_r <= misalign_r | is_misaligned(newpc);
      end else begin
         misalign_r <= misalign_r;
      end
   end

   ifid_reg u_ifid (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .hold       (stall),
      .load_pc    (pc_r),
      .load_instr (imem_rdata),
      .valid      (id_valid),
      .pc         (id_pc),
      .instr      (id_instr)
   );

`ifdef FETCH_FLUSH_COUNT_EN
   logic [15:0] flush_cnt_r;

   // Count redirect cycles, saturating rather than wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt_r <= 16'h0000;
      end else if (redirect && (flush_cnt_r != 16'hFFFF)) begin
         flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
         flush_cnt_r <= flush_cnt_r;
      end
   end

   assign flush_cnt = flush_cnt_r;
`else
   assign flush_cnt = 16'h0000;
`endif

   // Memory window is not range checked; addresses outside it alias
   assign word_off_s = word_offset(pc_r, IMEM_BASE);
   assign imem_addr  = IMEM_AW'(word_off_s);
   assign pc         = pc_r;
   assign pcen       = ~stall | redirect;
   assign misalign   = misalign_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with immediate-assertion checks.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] newpc;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic        pcen;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        misalign;
   logic [15:0] flush_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .redirect   (redirect),
      .newpc      (newpc),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .pcen       (pcen),
      .id_pc      (id_pc),
      .id_instr   (id_instr),
      .id_valid   (id_valid),
      .misalign   (misalign),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   // Address-tagged instruction memory
   assign imem_rdata = 32'hDEAD_0000 | {22'd0, imem_addr};

   // Expected instruction word fetched at byte address p
   function automatic logic [31:0] tag(input logic [31:0] p);
      logic [31:0] w;
      w = (p - 32'h0000_3000) >> 2;
      return 32'hDEAD_0000 | (w & 32'h0000_03FF);
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string name, input logic [31:0] epc, input logic [31:0] einstr,
                           input logic evalid);
      check({name, "_id_pc"}, id_pc, epc);
      check({name, "_id_instr"}, id_instr, einstr);
      check({name, "_id_valid"}, {31'd0, id_valid}, {31'd0, evalid});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; newpc = 32'h0;
      // Reset state
      step();
      check("rst_pc", pc, 32'h0000_3000);
      check_id("rst", 32'h0, 32'h0, 1'b0);
      check("rst_misalign", {31'd0, misalign}, 32'h0);
      check("rst_flush_cnt", {16'd0, flush_cnt}, 32'h0);
      check("rst_imem_addr", {22'd0, imem_addr}, 32'h0);
      rst = 1'b0;

      // Free-run fetch
      step();
      check("run1_pc", pc, 32'h0000_3004);
      check_id("run1", 32'h3000, tag(32'h3000), 1'b1);
      step();
      check("run2_pc", pc, 32'h0000_3008);
      check_id("run2", 32'h3004, tag(32'h3004), 1'b1);

      // Stall for three cycles at pc=3008
      stall = 1'b1;
      #1;
      check("stall_pcen", {31'd0, pcen}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", pc, 32'h0000_3008);
         check_id("stall", 32'h3004, tag(32'h3004), 1'b1);
      end
      stall = 1'b0;
      step();
      check("resume_pc", pc, 32'h0000_300C);
      check_id("resume", 32'h3008, tag(32'h3008), 1'b1);
      step();
      check("run3_pc", pc, 32'h0000_3010);
      check_id("run3", 32'h300C, tag(32'h300C), 1'b1);

      // Redirect to 3040
      redirect = 1'b1; newpc = 32'h0000_3040;
      step();
      check("redir_pc", pc, 32'h0000_3040);
      check_id("redir", 32'h0, 32'h0, 1'b0);
      redirect = 1'b0;
      step();
      check("redir2_pc", pc, 32'h0000_3044);
      check_id("redir2", 32'h3040, tag(32'h3040), 1'b1);

      // Redirect and stall together
      redirect = 1'b1; stall = 1'b1; newpc = 32'h0000_3100;
      #1;
      check("rs_pcen", {31'd0, pcen}, 32'h1);
      step();
      check("rs_pc", pc, 32'h0000_3100);
      check_id("rs", 32'h0, 32'h0, 1'b0);
      redirect = 1'b0; stall = 1'b0;
      step();
      check("rs2_pc", pc, 32'h0000_3104);
      check_id("rs2", 32'h3100, tag(32'h3100), 1'b1);
      check("rs2_misalign", {31'd0, misalign}, 32'h0);

      // Misaligned redirect target
      redirect = 1'b1; newpc = 32'h0000_3042;
      step();
      check("mis_pc", pc, 32'h0000_3040);
      check("mis_flag", {31'd0, misalign}, 32'h1);
      check_id("mis", 32'h0, 32'h0, 1'b0);
      redirect = 1'b0;
      step();
      check("mis2_pc", pc, 32'h0000_3044);
      check("mis2_flag", {31'd0, misalign}, 32'h1);
      check("mis2_imem_addr", {22'd0, imem_addr}, 32'h11);
      check_id("mis2", 32'h3040, tag(32'h3040), 1'b1);

      // Back-to-back redirects
      redirect = 1'b1; newpc = 32'h0000_3200;
      step();
      check("b2b1_pc", pc, 32'h0000_3200);
      newpc = 32'h0000_3300;
      step();
      check("b2b2_pc", pc, 32'h0000_3300);
      check_id("b2b2", 32'h0, 32'h0, 1'b0);
      redirect = 1'b0;
      step();
      check_id("b2b3", 32'h3300, tag(32'h3300), 1'b1);

      // Wrap at top of address space; imem_addr aliases
      redirect = 1'b1; newpc = 32'hFFFF_FFFC;
      step();
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_imem_addr", {22'd0, imem_addr}, 32'h3FF);
      redirect = 1'b0;
      step();
      check("wrap2_pc", pc, 32'h0000_0000);
      check_id("wrap2", 32'hFFFF_FFFC, 32'hDEAD_03FF, 1'b1);
      check("wrap2_misalign", {31'd0, misalign}, 32'h1);

      // Reset during a redirect
      rst = 1'b1; redirect = 1'b1; stall = 1'b1; newpc = 32'h0000_3500;
      step();
      check("rstr_pc", pc, 32'h0000_3000);
      check_id("rstr", 32'h0, 32'h0, 1'b0);
      check("rstr_misalign", {31'd0, misalign}, 32'h0);
      check("rstr_flush_cnt", {16'd0, flush_cnt}, 32'h0);
      rst = 1'b0; redirect = 1'b0; stall = 1'b0;
      step();
      check("rstr2_pc", pc, 32'h0000_3004);
      check_id("rstr2", 32'h3000, tag(32'h3000), 1'b1);

      // Redirect counter
      redirect = 1'b1; newpc = 32'h0000_3000;
      for (int i = 0; i < 3; i++) step();
`ifdef FETCH_FLUSH_COUNT_EN
      check("cnt3", {16'd0, flush_cnt}, 32'h3);
      for (int i = 0; i < 65531; i++) step();
      check("cnt_fffe", {16'd0, flush_cnt}, 32'h0000_FFFE);
      step();
      step();
      check("cnt_sat", {16'd0, flush_cnt}, 32'h0000_FFFF);
`else
      check("cnt_off", {16'd0, flush_cnt}, 32'h0);
`endif
      redirect = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
